// File: rtl/conv_stream_sequencer.sv
// Sequencing controller for the KxK line/window-buffer convolution engine.
// Counts the raster IFM stream, steers buffer writes, flags windows and aligns MAC output strobes.
module conv_stream_sequencer #(
    parameter int unsigned IMG_W   = 14,
    parameter int unsigned IMG_H   = 14,
    parameter int unsigned K       = 3,
    parameter int unsigned MAC_LAT = 1,
    localparam int unsigned NPIX    = IMG_W * IMG_H,
    localparam int unsigned NWGT    = K * K,
    localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int unsigned BEAT_W  = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int unsigned WADDR_W = (NWGT > 1) ? $clog2(NWGT) : 1,
    localparam int unsigned LBROW_W = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned WROW_W  = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1,
    localparam int unsigned WCOL_W  = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1,
    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               wgt_we,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               lb_we,
    output logic [LBROW_W-1:0] lb_row,
    output logic [COL_W-1:0]   lb_col,
    output logic               win_valid,
    output logic [WROW_W-1:0]  win_row,
    output logic [WCOL_W-1:0]  win_col,
    output logic               out_valid,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    state_t               state;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [BEAT_W-1:0]    beat;
    logic [LBROW_W-1:0]   lb_row_q;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 win_last;
    logic [MAC_LAT-1:0]   vpipe;
    logic [MAC_LAT-1:0]   lpipe;

    logic col_last, row_last, frame_last, win_hit;

    assign col_last   = (col == COL_W'(IMG_W - 1));
    assign row_last   = (row == ROW_W'(IMG_H - 1));
    assign frame_last = col_last && row_last;
    assign win_hit    = in_valid && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

    // Buffer write steering follows the current (not yet accepted) beat position.
    assign wgt_we   = in_valid && (beat < BEAT_W'(NWGT));
    assign wgt_addr = wgt_we ? WADDR_W'(beat) : '0;
    assign lb_we    = in_valid;
    assign lb_row   = lb_row_q;
    assign lb_col   = col;
    assign busy     = (state != S_IDLE);

    // Raster position counters; lb_row_q tracks row mod K without a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            beat     <= '0;
            lb_row_q <= '0;
        end else if (in_valid) begin
            beat <= frame_last ? '0 : beat + BEAT_W'(1);
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row      <= '0;
                    lb_row_q <= '0;
                end else begin
                    row      <= row + ROW_W'(1);
                    lb_row_q <= (lb_row_q == LBROW_W'(K - 1)) ? '0 : lb_row_q + LBROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Window flag and coordinates for the beat accepted at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= win_hit;
            win_last  <= win_hit && frame_last;
            if (win_hit) begin
                win_row <= WROW_W'(row - ROW_W'(K - 1));
                win_col <= WCOL_W'(col - COL_W'(K - 1));
            end
        end
    end

    // MAC latency pipe; free-running so a previous frame drains regardless of input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= win_valid;
            lpipe[0] <= win_last;
            for (int i = 1; i < MAC_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    assign out_valid  = vpipe[MAC_LAT-1];
    assign frame_done = lpipe[MAC_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid && col_last && (row == ROW_W'(K - 2))) state <= S_STREAM;
                end
                S_STREAM: begin
                    if (in_valid && frame_last) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (in_valid) begin
                        state <= S_LOAD;
                    end else if (drain_cnt == DRAIN_W'(MAC_LAT - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Directed bench for conv_stream_sequencer: one instance at MAC_LAT=1 and one at MAC_LAT=3
// share the same stimulus.
module tb_conv_stream_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;

    logic       wgt_we, lb_we, win_valid, out_valid, frame_done, busy;
    logic [3:0] wgt_addr, lb_col, win_row, win_col;
    logic [1:0] lb_row;

    logic       wgt_we3, lb_we3, win_valid3, out_valid3, frame_done3, busy3;
    logic [3:0] wgt_addr3, lb_col3, win_row3, win_col3;
    logic [1:0] lb_row3;

    conv_stream_sequencer #(.MAC_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .lb_we(lb_we), .lb_row(lb_row), .lb_col(lb_col),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
    );

    conv_stream_sequencer #(.MAC_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .wgt_we(wgt_we3), .wgt_addr(wgt_addr3), .lb_we(lb_we3), .lb_row(lb_row3), .lb_col(lb_col3),
        .win_valid(win_valid3), .win_row(win_row3), .win_col(win_col3),
        .out_valid(out_valid3), .frame_done(frame_done3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_win, n_out, n_fd, n_win3, n_out3, n_fd3;
    int first_win, first_out, first_win3, first_out3, fd_cyc, fd_cyc3;
    int beat30_cyc, last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        n_win = 0; n_out = 0; n_fd = 0; n_win3 = 0; n_out3 = 0; n_fd3 = 0;
        first_win = -1; first_out = -1; first_win3 = -1; first_out3 = -1;
        fd_cyc = -1; fd_cyc3 = -1;
    endtask

    // Event monitor; sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid)  begin if (n_win == 0)  first_win  = cyc; n_win++;  end
            if (out_valid)  begin if (n_out == 0)  first_out  = cyc; n_out++;  end
            if (win_valid3) begin if (n_win3 == 0) first_win3 = cyc; n_win3++; end
            if (out_valid3) begin if (n_out3 == 0) first_out3 = cyc; n_out3++; end
            if (frame_done)  begin n_fd++;  fd_cyc  = cyc; check("fd_with_out_valid",  out_valid,  1); end
            if (frame_done3) begin n_fd3++; fd_cyc3 = cyc; check("fd3_with_out_valid", out_valid3, 1); end
        end
    end

    // One cycle: drive in_valid, check steering, then check the registered result after the edge.
    task automatic step(input logic v, input int b);
        int r, c;
        r = b / 14;
        c = b % 14;
        in_valid = v;
        #1;
        check("lb_we", lb_we, v);
        check("wgt_we", wgt_we, (v && b < 9) ? 1 : 0);
        check("wgt_addr", wgt_addr, (v && b < 9) ? b : 0);
        if (v) begin
            check("lb_col", lb_col, c);
            check("lb_row", lb_row, r % 3);
        end
        @(negedge clk);
        if (v) begin
            check("win_valid", win_valid, (r >= 2 && c >= 2) ? 1 : 0);
            check("win_valid3", win_valid3, (r >= 2 && c >= 2) ? 1 : 0);
            if (r >= 2 && c >= 2) begin
                check("win_row", win_row, r - 2);
                check("win_col", win_col, c - 2);
            end
            check("busy_stream", busy, 1);
            check("busy3_stream", busy3, 1);
            if (b == 30)  beat30_cyc = cyc;
            if (b == 195) last_cyc   = cyc;
        end else begin
            check("win_valid_idle", win_valid, 0);
        end
    endtask

    task automatic run_frame();
        for (int b = 0; b < 196; b++) step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic check_totals(input string tag, input int nw, input int nf);
        check({tag, "_win"},  n_win,  nw);
        check({tag, "_out"},  n_out,  nw);
        check({tag, "_fd"},   n_fd,   nf);
        check({tag, "_out3"}, n_out3, nw);
        check({tag, "_fd3"},  n_fd3,  nf);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_win_row"}, win_row, 0);
        check({tag, "_win_col"}, win_col, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_lb_col"}, lb_col, 0);
        check({tag, "_lb_row"}, lb_row, 0);
        check({tag, "_wgt_we"}, wgt_we, 0);
        check({tag, "_out_valid3"}, out_valid3, 0);
        check({tag, "_busy3"}, busy3, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1/T2: one contiguous frame at both latencies
        clear_counts();
        run_frame();
        step(1'b0, 0);
        check("t1_busy_after_drain", busy, 0);
        check("t6_busy3_drain1", busy3, 1);
        step(1'b0, 0);
        check("t6_busy3_drain2", busy3, 1);
        step(1'b0, 0);
        check("t6_busy3_idle", busy3, 0);
        idle(4);
        check_totals("t1", 144, 1);
        check("t1_first_win_cyc", first_win, beat30_cyc);
        check("t1_first_out_cyc", first_out, beat30_cyc + 1);
        check("t6_first_out3_cyc", first_out3, beat30_cyc + 3);
        check("t1_fd_cyc", fd_cyc, last_cyc + 1);
        check("t6_fd3_cyc", fd_cyc3, last_cyc + 3);

        // T3: five-cycle gap after beat 100
        clear_counts();
        for (int b = 0; b <= 100; b++) step(1'b1, b);
        idle(5);
        check("t3_busy_gap", busy, 1);
        for (int b = 101; b < 196; b++) step(1'b1, b);
        idle(8);
        check_totals("t3", 144, 1);

        // T4: two frames back to back
        clear_counts();
        run_frame();
        run_frame();
        idle(8);
        check_totals("t4", 288, 2);

        // T5: reset mid-frame at beat 120, then a clean frame
        clear_counts();
        for (int b = 0; b < 120; b++) step(1'b1, b);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        idle(6);
        check("t5_no_stale_out", n_out, 0);
        check("t5_no_stale_out3", n_out3, 0);
        check("t5_no_fd", n_fd + n_fd3, 0);
        check("t5_idle_busy", busy, 0);
        clear_counts();
        run_frame();
        idle(8);
        check_totals("t5", 144, 1);
        check("t5_first_win_cyc", first_win, beat30_cyc);
        check("t5_fd_cyc", fd_cyc, last_cyc + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
